// File: rtl/signature_compactor.sv
// Signature compactor: drives a stimulus counter and folds observed channel
// bytes into a rotating signature, then compares against a golden value.
module signature_compactor #(
  parameter int SIG_W  = 16,
  parameter int STIM_W = 8,
  parameter int CH     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              mode,
  input  logic [7:0]        seed,
  input  logic [SIG_W-1:0]  expected_sig,
  input  logic [CH*8-1:0]   ch_data,
  output logic [STIM_W-1:0] stimulus,
  output logic [SIG_W-1:0]  signature,
  output logic              busy,
  output logic              done,
  output logic              pass
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [7:0]       seed_q;
  logic             mode_q;
  logic [SIG_W-1:0] exp_q;
  logic [7:0]       scr;
  logic [7:0]       sum;
  logic [SIG_W-1:0] t;
  logic [SIG_W-1:0] sig_nx;
  logic             full;
  logic             enter;

  always_comb begin
    scr = seed_q;
    for (int n = 0; n < CH; n++) begin
      scr = scr ^ ch_data[8*n +: 8];
    end
  end

  // Low byte replaced by the sum, then the whole word rotated left.
  always_comb begin
    sum    = signature[7:0] + scr;
    t      = {signature[SIG_W-1:8], sum};
    sig_nx = mode_q ? ((t << 2) | (t >> (SIG_W-2)))
                    : ((t << 1) | (t >> (SIG_W-1)));
  end

  assign full  = &stimulus;
  assign enter = (state != RUN) && (state_nx == RUN);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (!abort && start) state_nx = RUN;
      RUN: begin
        if (abort)     state_nx = IDLE;
        else if (full) state_nx = DONE;
      end
      DONE: begin
        if (abort)      state_nx = IDLE;
        else if (start) state_nx = RUN;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      stimulus  <= '0;
      signature <= '0;
      pass      <= 1'b0;
      seed_q    <= '0;
      mode_q    <= 1'b0;
      exp_q     <= '0;
    end else begin
      state <= state_nx;
      if (enter) begin
        stimulus  <= '0;
        signature <= '0;
        pass      <= 1'b0;
        seed_q    <= seed;
        mode_q    <= mode;
        exp_q     <= expected_sig;
      end else if (state == RUN) begin
        if (abort) begin
          stimulus <= '0;
          pass     <= 1'b0;
        end else if (!full) begin
          signature <= sig_nx;
          stimulus  <= stimulus + STIM_W'(1);
        end else begin
          pass <= (signature == exp_q);
        end
      end else if (abort) begin
        pass <= 1'b0;
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule
